// File: rtl/tcm_arb_pkg.sv
// rtl/tcm_arb_pkg.sv - shared types and constants for the TCM port arbiter
package tcm_arb_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_I    = 2'd1,
        RESP_D    = 2'd2
    } resp_src_t;

    localparam logic [31:0] TCM_BASE_ADDR_DEFAULT = 32'h8000_0000;
    localparam int          TAG_W                 = 11;

endpackage

// File: rtl/tcm_arb_rr.sv
// rtl/tcm_arb_rr.sv - 2-way round-robin grant, pointer flips only on contention
module tcm_arb_rr (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i_i,
    input  logic req_d_i,
    output logic gnt_i_o,
    output logic gnt_d_o
);

    // ptr_q = 0 favours the fetch port, 1 favours the data port
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_i_o = 1'b0;
        gnt_d_o = 1'b0;
        ptr_d   = ptr_q;
        if (!rst_i) begin
            if (req_i_i && req_d_i) begin
                gnt_i_o = ~ptr_q;
                gnt_d_o = ptr_q;
                ptr_d   = ~ptr_q;
            end else begin
                gnt_i_o = req_i_i;
                gnt_d_o = req_d_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tcm_port_arb.sv
// rtl/tcm_port_arb.sv - shares one single-ported 64-bit TCM between fetch and data ports
module tcm_port_arb
    import tcm_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TCM_BASE_ADDR_DEFAULT,
    parameter int          ADDR_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_i_rd_i,
    input  logic [31:0]       mem_i_pc_i,
    output logic              mem_i_accept_o,
    output logic              mem_i_valid_o,
    output logic              mem_i_error_o,
    output logic [63:0]       mem_i_inst_o,
    input  logic [31:0]       mem_d_addr_i,
    input  logic [31:0]       mem_d_data_wr_i,
    input  logic              mem_d_rd_i,
    input  logic [3:0]        mem_d_wr_i,
    input  logic [TAG_W-1:0]  mem_d_req_tag_i,
    output logic              mem_d_accept_o,
    output logic              mem_d_ack_o,
    output logic              mem_d_error_o,
    output logic [31:0]       mem_d_data_rd_o,
    output logic [TAG_W-1:0]  mem_d_resp_tag_o,
    output logic              ram_en_o,
    output logic [ADDR_W-4:0] ram_addr_o,
    output logic [7:0]        ram_be_o,
    output logic [63:0]       ram_wdata_o,
    input  logic [63:0]       ram_rdata_i
);

    logic        d_req;
    logic        d_is_wr;
    logic        gnt_i;
    logic        gnt_d;
    logic [31:0] off_i;
    logic [31:0] off_d;
    logic        in_range_i;
    logic        in_range_d;

    resp_src_t        resp_q, resp_d;
    logic             err_q, err_d;
    logic             wr_q, wr_d;
    logic             hi_q, hi_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic unused_bits;

    assign d_is_wr = |mem_d_wr_i;
    assign d_req   = mem_d_rd_i | d_is_wr;

    tcm_arb_rr u_rr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i_i (mem_i_rd_i),
        .req_d_i (d_req),
        .gnt_i_o (gnt_i),
        .gnt_d_o (gnt_d)
    );

    // Unsigned wrap-around subtract: anything below BASE_ADDR lands far out of range
    assign off_i      = mem_i_pc_i - BASE_ADDR;
    assign off_d      = mem_d_addr_i - BASE_ADDR;
    assign in_range_i = (off_i[31:ADDR_W] == '0);
    assign in_range_d = (off_d[31:ADDR_W] == '0);

    assign unused_bits = ^{off_i[2:0], off_d[1:0]};

    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_be_o    = 8'h00;
        ram_wdata_o = 64'h0;
        resp_d      = RESP_NONE;
        err_d       = 1'b0;
        wr_d        = 1'b0;
        hi_d        = 1'b0;
        tag_d       = '0;
        if (gnt_i) begin
            ram_en_o   = in_range_i;
            ram_addr_o = off_i[ADDR_W-1:3];
            resp_d     = RESP_I;
            err_d      = ~in_range_i;
        end else if (gnt_d) begin
            ram_en_o   = in_range_d;
            ram_addr_o = off_d[ADDR_W-1:3];
            resp_d     = RESP_D;
            err_d      = ~in_range_d;
            wr_d       = d_is_wr;
            hi_d       = off_d[2];
            tag_d      = mem_d_req_tag_i;
            if (d_is_wr && in_range_d) begin
                ram_wdata_o = {mem_d_data_wr_i, mem_d_data_wr_i};
                ram_be_o    = off_d[2] ? {mem_d_wr_i, 4'b0000} : {4'b0000, mem_d_wr_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q <= RESP_NONE;
            err_q  <= 1'b0;
            wr_q   <= 1'b0;
            hi_q   <= 1'b0;
            tag_q  <= '0;
        end else begin
            resp_q <= resp_d;
            err_q  <= err_d;
            wr_q   <= wr_d;
            hi_q   <= hi_d;
            tag_q  <= tag_d;
        end
    end

    assign mem_i_accept_o = gnt_i;
    assign mem_d_accept_o = gnt_d;

    // Responses are masked while reset is high so an in-flight access never surfaces
    always_comb begin
        mem_i_valid_o    = 1'b0;
        mem_i_error_o    = 1'b0;
        mem_i_inst_o     = 64'h0;
        mem_d_ack_o      = 1'b0;
        mem_d_error_o    = 1'b0;
        mem_d_data_rd_o  = 32'h0;
        mem_d_resp_tag_o = '0;
        if (!rst_i) begin
            if (resp_q == RESP_I) begin
                mem_i_valid_o = 1'b1;
                mem_i_error_o = err_q;
                mem_i_inst_o  = err_q ? 64'h0 : ram_rdata_i;
            end
            if (resp_q == RESP_D) begin
                mem_d_ack_o      = 1'b1;
                mem_d_error_o    = err_q;
                mem_d_resp_tag_o = tag_q;
                if (!err_q && !wr_q) begin
                    mem_d_data_rd_o = hi_q ? ram_rdata_i[63:32] : ram_rdata_i[31:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_tcm_port_arb.sv
// tb/tb_tcm_port_arb.sv - directed self-checking bench for tcm_port_arb
module tb_tcm_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rd;
    logic [31:0] i_pc;
    logic        i_acc, i_valid, i_err;
    logic [63:0] i_inst;
    logic [31:0] d_addr, d_wdata;
    logic        d_rd;
    logic [3:0]  d_wr;
    logic [10:0] d_tag;
    logic        d_acc, d_ack, d_err;
    logic [31:0] d_rdata;
    logic [10:0] d_rtag;
    logic        ram_en;
    logic [12:0] ram_addr;
    logic [7:0]  ram_be;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;

    logic [63:0] mem [0:15];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    tcm_port_arb dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem_i_rd_i       (i_rd),
        .mem_i_pc_i       (i_pc),
        .mem_i_accept_o   (i_acc),
        .mem_i_valid_o    (i_valid),
        .mem_i_error_o    (i_err),
        .mem_i_inst_o     (i_inst),
        .mem_d_addr_i     (d_addr),
        .mem_d_data_wr_i  (d_wdata),
        .mem_d_rd_i       (d_rd),
        .mem_d_wr_i       (d_wr),
        .mem_d_req_tag_i  (d_tag),
        .mem_d_accept_o   (d_acc),
        .mem_d_ack_o      (d_ack),
        .mem_d_error_o    (d_err),
        .mem_d_data_rd_o  (d_rdata),
        .mem_d_resp_tag_o (d_rtag),
        .ram_en_o         (ram_en),
        .ram_addr_o       (ram_addr),
        .ram_be_o         (ram_be),
        .ram_wdata_o      (ram_wdata),
        .ram_rdata_i      (ram_rdata)
    );

    // Synchronous RAM model; only the low 16 words are ever touched
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_be == 8'h00) begin
                ram_rdata <= mem[ram_addr[3:0]];
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (ram_be[b]) mem[ram_addr[3:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_rd = 1'b0; i_pc = 32'h0;
        d_rd = 1'b0; d_wr = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; d_tag = 11'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_rd = 1'b1; i_pc = 32'h8000_0008;
        d_rd = 1'b1; d_addr = 32'h8000_0000; d_tag = 11'h3;
        tick(); tick(); #2;
        checks++; if (i_acc !== 1'b0) begin fails++; $display("FAIL reset_i_acc got=%b exp=0", i_acc); end
        checks++; if (d_acc !== 1'b0) begin fails++; $display("FAIL reset_d_acc got=%b exp=0", d_acc); end
        checks++; if (ram_en !== 1'b0) begin fails++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
        checks++; if ({i_valid, i_err, d_ack, d_err} !== 4'b0) begin fails++; $display("FAIL reset_resp got=%b exp=0000", {i_valid, i_err, d_ack, d_err}); end
        checks++; if (i_inst !== 64'h0 || d_rdata !== 32'h0 || d_rtag !== 11'h0) begin fails++; $display("FAIL reset_data got=%h/%h/%h exp=0", i_inst, d_rdata, d_rtag); end
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        tick();
        i_rd = 1'b1; i_pc = 32'h8000_0008; #2;
        checks++; if (i_acc !== 1'b1 || d_acc !== 1'b0) begin fails++; $display("FAIL fetch_acc got=%b%b exp=10", i_acc, d_acc); end
        checks++; if (ram_en !== 1'b1 || ram_addr !== 13'd1 || ram_be !== 8'h00) begin fails++; $display("FAIL fetch_ram got en=%b addr=%h be=%h exp 1/1/00", ram_en, ram_addr, ram_be); end
        tick();
        idle(); #2;
        checks++; if (i_valid !== 1'b1 || i_err !== 1'b0) begin fails++; $display("FAIL fetch_valid got=%b err=%b exp=1/0", i_valid, i_err); end
        checks++; if (i_inst !== 64'h1122334455667788) begin fails++; $display("FAIL fetch_inst got=%h exp=1122334455667788", i_inst); end
        tick(); #2;
        checks++; if (i_valid !== 1'b0) begin fails++; $display("FAIL fetch_single got=%b exp=0", i_valid); end
    endtask

    task automatic test_write_read();
        tick();
        d_addr = 32'h8000_0004; d_wdata = 32'hDEADBEEF; d_wr = 4'hF; d_tag = 11'h155; #2;
        checks++; if (d_acc !== 1'b1 || ram_en !== 1'b1) begin fails++; $display("FAIL wr_acc got acc=%b en=%b exp=1/1", d_acc, ram_en); end
        checks++; if (ram_be !== 8'hF0) begin fails++; $display("FAIL wr_be got=%h exp=f0", ram_be); end
        checks++; if (ram_wdata !== 64'hDEADBEEFDEADBEEF) begin fails++; $display("FAIL wr_wdata got=%h exp=deadbeefdeadbeef", ram_wdata); end
        tick();
        d_wr = 4'h0; d_wdata = 32'h0; d_rd = 1'b1; d_tag = 11'h0AA; #2;
        checks++; if (d_ack !== 1'b1 || d_rtag !== 11'h155 || d_err !== 1'b0) begin fails++; $display("FAIL wr_ack got ack=%b tag=%h err=%b exp=1/155/0", d_ack, d_rtag, d_err); end
        checks++; if (d_rdata !== 32'h0) begin fails++; $display("FAIL wr_rdata got=%h exp=0", d_rdata); end
        checks++; if (ram_be !== 8'h00 || d_acc !== 1'b1) begin fails++; $display("FAIL rd_req got be=%h acc=%b exp=00/1", ram_be, d_acc); end
        tick();
        idle(); #2;
        checks++; if (d_ack !== 1'b1 || d_rtag !== 11'h0AA) begin fails++; $display("FAIL rd_ack got ack=%b tag=%h exp=1/0aa", d_ack, d_rtag); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got=%h exp=deadbeef", d_rdata); end
    endtask

    task automatic test_contention();
        for (int k = 0; k <= 6; k++) begin
            tick();
            if (k < 6) begin
                i_rd = 1'b1; i_pc = 32'h8000_0008;
                d_rd = 1'b1; d_addr = 32'h8000_0004; d_tag = 11'h10 + 11'(k);
            end else begin
                idle();
            end
            #2;
            if (k < 6) begin
                checks++;
                if (i_acc !== (k % 2 == 0) || d_acc !== (k % 2 == 1)) begin
                    fails++; $display("FAIL rr_grant k=%0d got=%b%b exp=%b%b", k, i_acc, d_acc, k % 2 == 0, k % 2 == 1);
                end
            end
            if (k > 0) begin
                checks++;
                if (i_valid !== ((k - 1) % 2 == 0) || d_ack !== ((k - 1) % 2 == 1)) begin
                    fails++; $display("FAIL rr_resp k=%0d got valid=%b ack=%b", k, i_valid, d_ack);
                end
                if ((k - 1) % 2 == 0) begin
                    checks++; if (i_inst !== 64'h1122334455667788) begin fails++; $display("FAIL rr_inst k=%0d got=%h exp=1122334455667788", k, i_inst); end
                end else begin
                    checks++; if (d_rdata !== 32'hDEADBEEF || d_rtag !== 11'h10 + 11'(k - 1)) begin fails++; $display("FAIL rr_data k=%0d got=%h tag=%h exp=deadbeef tag=%h", k, d_rdata, d_rtag, 11'h10 + 11'(k - 1)); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= 3; k++) begin
            tick();
            if (k < 3) begin
                i_rd = 1'b1; i_pc = (k % 2 == 0) ? 32'h8000_0008 : 32'h8000_0000;
            end else begin
                idle();
            end
            #2;
            if (k < 3) begin
                checks++; if (i_acc !== 1'b1) begin fails++; $display("FAIL b2b_acc k=%0d got=%b exp=1", k, i_acc); end
            end
            if (k > 0) begin
                checks++;
                if (i_valid !== 1'b1 || i_inst !== (((k - 1) % 2 == 0) ? 64'h1122334455667788 : 64'hDEADBEEF00000000)) begin
                    fails++; $display("FAIL b2b_resp k=%0d got valid=%b inst=%h", k, i_valid, i_inst);
                end
            end
        end
    endtask

    task automatic test_error();
        tick();
        d_rd = 1'b1; d_addr = 32'h9000_0000; d_tag = 11'h7FF; #2;
        checks++; if (d_acc !== 1'b1 || ram_en !== 1'b0) begin fails++; $display("FAIL err_req got acc=%b en=%b exp=1/0", d_acc, ram_en); end
        tick();
        idle(); #2;
        checks++; if (d_ack !== 1'b1 || d_err !== 1'b1) begin fails++; $display("FAIL err_ack got ack=%b err=%b exp=1/1", d_ack, d_err); end
        checks++; if (d_rdata !== 32'h0 || d_rtag !== 11'h7FF) begin fails++; $display("FAIL err_data got=%h tag=%h exp=0/7ff", d_rdata, d_rtag); end
    endtask

    task automatic test_reset_inflight();
        // Contended grant leaves the pointer favouring D before the reset
        tick();
        i_rd = 1'b1; i_pc = 32'h8000_0008; d_rd = 1'b1; d_addr = 32'h8000_0004; d_tag = 11'h1;
        tick();
        d_rd = 1'b0; #2;
        checks++; if (i_acc !== 1'b1) begin fails++; $display("FAIL rst_fetch_acc got=%b exp=1", i_acc); end
        tick();
        idle(); rst = 1'b1; #2;
        checks++; if (i_valid !== 1'b0) begin fails++; $display("FAIL rst_suppress got=%b exp=0", i_valid); end
        tick();
        rst = 1'b0;
        i_rd = 1'b1; i_pc = 32'h8000_0008; d_rd = 1'b1; d_addr = 32'h8000_0004; d_tag = 11'h2; #2;
        checks++; if (i_valid !== 1'b0) begin fails++; $display("FAIL rst_late_valid got=%b exp=0", i_valid); end
        checks++; if (i_acc !== 1'b1 || d_acc !== 1'b0) begin fails++; $display("FAIL rst_ptr got=%b%b exp=10", i_acc, d_acc); end
        tick();
        idle();
        tick();
    endtask

    initial begin
        mem[0] = 64'h0;
        mem[1] = 64'h1122334455667788;
        ram_rdata = 64'h0;
        idle();
        test_reset();
        test_fetch();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_error();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
